// File: rtl/if_prefetch.sv
// Instruction fetch front end: issues sequential word fetches on a
// request/grant memory bus, buffers returned words with their addresses in a
// small FIFO and hands them to IF/ID. A flush discards buffered words and
// marks in-flight responses for dropping, then restarts at the redirect PC.
//
// Handshakes:
//   imem: a request is transferred on a rising edge where imem_req_o and
//         imem_gnt_i are both 1; imem_addr_o is held stable until then.
//         Responses come back in request order on imem_rvalid_i.
//   IF/ID: the head is transferred on a rising edge where inst_valid_o and
//          inst_ready_i are both 1. inst_valid_o never depends on inst_ready_i.
module if_prefetch #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                  imem_req_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_gnt_i,
    input  logic                  imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic                  inst_valid_o,
    input  logic                  inst_ready_i,
    output logic [DATA_WIDTH-1:0] inst_o,
    output logic [ADDR_WIDTH-1:0] inst_addr_o
);

    // CW holds 0..DEPTH, PW indexes the FIFO storage.
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(DEPTH);
    localparam logic [DATA_WIDTH-1:0] NOP     = DATA_WIDTH'(32'h0000_0013);
    localparam logic [CW:0]           CREDITS = (CW+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] STEP    = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] ALIGN   = ~ADDR_WIDTH'(3);

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] resp_pc;
    logic [CW-1:0]         count;
    logic [CW-1:0]         outstanding;
    logic [CW-1:0]         discard;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];

    logic [CW:0]           credit_used;
    logic                  req;
    logic                  accept;
    logic                  resp;
    logic                  push;
    logic                  pop;
    logic [CW-1:0]         outstanding_nxt;
    logic [ADDR_WIDTH-1:0] redirect_aligned;

    // Issue/response/FIFO control decisions for this cycle.
    always_comb begin
        credit_used      = {1'b0, count} + {1'b0, outstanding};
        // Buffered plus in-flight never exceeds DEPTH, so a push can never
        // find the FIFO full. Held low during reset and on a flush cycle.
        req              = !rst_i && !flush_i && (credit_used < CREDITS);
        accept           = req && imem_gnt_i;
        // A response with nothing outstanding is a protocol error: ignored.
        resp             = imem_rvalid_i && (outstanding != '0);
        push             = resp && (discard == '0) && !flush_i;
        pop              = (count != '0) && inst_ready_i && !flush_i;
        outstanding_nxt  = outstanding + CW'(accept) - CW'(resp);
        redirect_aligned = redirect_pc_i & ALIGN;
    end

    // PCs, occupancy, outstanding/discard counters and FIFO pointers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (flush_i) begin
                // Every fetch still in flight after this edge belongs to the
                // old stream and must be dropped when it returns.
                fetch_pc <= redirect_aligned;
                resp_pc  <= redirect_aligned;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                discard  <= outstanding_nxt;
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + STEP;
                end
                if (resp && (discard != '0)) begin
                    discard <= discard - CW'(1);
                end
                if (push) begin
                    resp_pc <= resp_pc + STEP;
                    wr_ptr  <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // FIFO storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            data_mem[wr_ptr] <= imem_rdata_i;
            addr_mem[wr_ptr] <= resp_pc;
        end
    end

    // Fall-through head presentation and bus outputs.
    always_comb begin
        imem_req_o   = req;
        imem_addr_o  = fetch_pc;
        inst_valid_o = (count != '0);
        inst_o       = NOP;
        inst_addr_o  = '0;
        if (count != '0) begin
            inst_o      = data_mem[rd_ptr];
            inst_addr_o = addr_mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: table of per-cycle vectors (inputs plus expected
// outputs) applied in a loop, followed by hand-written corner sequences.
// The memory model returns each granted address as its data one cycle later.
module tb_if_prefetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] redirect;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        inst_valid;
  logic        ready;
  logic [31:0] inst;
  logic [31:0] inst_addr;

  int tests = 0;
  int fails = 0;

  // ---------------- clock/reset ----------------
  always #5 clk = ~clk;

  if_prefetch dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .flush_i       (flush),
    .redirect_pc_i (redirect),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_gnt_i    (gnt),
    .imem_rvalid_i (rvalid),
    .imem_rdata_i  (rdata),
    .inst_valid_o  (inst_valid),
    .inst_ready_i  (ready),
    .inst_o        (inst),
    .inst_addr_o   (inst_addr)
  );

  typedef struct {
    logic        rst;
    logic        ready;
    logic        gnt;
    logic        hold;   // memory withholds responses this cycle
    logic        flush;
    logic        spur;   // drive an rvalid with nothing requested
    logic [31:0] redir;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] eia;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];   // granted addresses awaiting a memory response
  logic        spur_now = 1'b0;

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic ereq, input logic [31:0] eaddr,
                            input logic evalid, input logic [31:0] eia);
    chk({tag, " req"}, {31'd0, imem_req}, {31'd0, ereq});
    chk({tag, " addr"}, imem_addr, eaddr);
    chk({tag, " valid"}, {31'd0, inst_valid}, {31'd0, evalid});
    chk({tag, " inst_addr"}, inst_addr, evalid ? eia : 32'd0);
    chk({tag, " inst"}, inst, evalid ? eia : NOP);
  endtask

  // ---------------- driver tasks ----------------
  function automatic vec_t mk(input logic r, input logic rdy, input logic g, input logic h,
                              input logic f, input logic sp, input logic [31:0] rd,
                              input logic eq, input logic [31:0] ea, input logic ev,
                              input logic [31:0] ei);
    vec_t v;
    v.rst = r; v.ready = rdy; v.gnt = g; v.hold = h; v.flush = f; v.spur = sp;
    v.redir = rd; v.ereq = eq; v.eaddr = ea; v.evalid = ev; v.eia = ei;
    return v;
  endfunction

  task automatic add(input logic r, input logic rdy, input logic g, input logic h,
                     input logic f, input logic [31:0] rd, input logic eq,
                     input logic [31:0] ea, input logic ev, input logic [31:0] ei);
    vecs.push_back(mk(r, rdy, g, h, f, 1'b0, rd, eq, ea, ev, ei));
  endtask

  task automatic drive(input vec_t v);
    rst      = v.rst;
    ready    = v.ready;
    gnt      = v.gnt;
    flush    = v.flush;
    redirect = v.redir;
    if (v.rst) exp_q.delete();
    if (v.spur) begin
      spur_now = 1'b1;
      rvalid   = 1'b1;
      rdata    = 32'hDEAD_BEEF;
    end else begin
      spur_now = 1'b0;
      rvalid   = !v.rst && !v.hold && (exp_q.size() > 0);
      rdata    = rvalid ? exp_q[0] : 32'd0;
    end
  endtask

  // Advance one clock and update the memory model with what happened at the edge.
  task automatic step();
    logic        req_pre;
    logic        gnt_pre;
    logic        rv_pre;
    logic [31:0] addr_pre;
    req_pre  = imem_req;
    gnt_pre  = gnt;
    addr_pre = imem_addr;
    rv_pre   = rvalid && !spur_now;
    @(posedge clk);
    #1;
    if (rv_pre && exp_q.size() > 0) void'(exp_q.pop_front());
    if (req_pre && gnt_pre) exp_q.push_back(addr_pre);
  endtask

  task automatic apply(input vec_t v, input string tag);
    drive(v);
    #1;
    check_outs(tag, v.ereq, v.eaddr, v.evalid, v.eia);
    step();
  endtask

  // ---------------- test ----------------
  initial begin
    rst = 1'b1; flush = 1'b0; redirect = '0; gnt = 1'b0;
    rvalid = 1'b0; rdata = '0; ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Streaming from reset: addr-as-data, one instruction per cycle after startup.
    //  rst rdy gnt hld fl redir          req addr          vld inst_addr
    add(1, 1, 1, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0);
    add(0, 1, 1, 0, 0, 32'h0,          1, 32'h0,          0, 32'h0);
    add(0, 1, 1, 0, 0, 32'h0,          1, 32'h4,          0, 32'h0);
    add(0, 1, 1, 0, 0, 32'h0,          1, 32'h8,          1, 32'h0);
    add(0, 1, 1, 0, 0, 32'h0,          1, 32'hC,          1, 32'h4);
    add(0, 1, 1, 0, 0, 32'h0,          1, 32'h10,         1, 32'h8);
    add(0, 1, 1, 0, 0, 32'h0,          1, 32'h14,         1, 32'hC);
    // Stall with ready=0: exactly four grants, then request drops.
    add(1, 0, 1, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0);
    add(0, 0, 1, 0, 0, 32'h0,          1, 32'h0,          0, 32'h0);
    add(0, 0, 1, 0, 0, 32'h0,          1, 32'h4,          0, 32'h0);
    add(0, 0, 1, 0, 0, 32'h0,          1, 32'h8,          1, 32'h0);
    add(0, 0, 1, 0, 0, 32'h0,          1, 32'hC,          1, 32'h0);
    for (int i = 0; i < 6; i++)
      add(0, 0, 1, 0, 0, 32'h0,        0, 32'h10,         1, 32'h0);
    // Release: drain in order, fetch resumes at 0x10.
    add(0, 1, 1, 0, 0, 32'h0,          0, 32'h10,         1, 32'h0);
    add(0, 1, 1, 0, 0, 32'h0,          1, 32'h10,         1, 32'h4);
    add(0, 1, 1, 0, 0, 32'h0,          1, 32'h14,         1, 32'h8);
    add(0, 1, 1, 0, 0, 32'h0,          1, 32'h18,         1, 32'hC);
    add(0, 1, 1, 0, 0, 32'h0,          1, 32'h1C,         1, 32'h10);
    add(0, 1, 1, 0, 0, 32'h0,          1, 32'h20,         1, 32'h14);
    // Grant withheld for 5 cycles: request and address hold.
    for (int i = 0; i < 5; i++)
      add(0, 0, 0, 0, 0, 32'h0,        1, 32'h24,         1, 32'h18);
    // Flush with FIFO {8,C} and two fetches {10,14} in flight.
    add(1, 0, 1, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0);
    add(0, 0, 1, 0, 0, 32'h0,          1, 32'h0,          0, 32'h0);
    add(0, 0, 1, 0, 0, 32'h0,          1, 32'h4,          0, 32'h0);
    add(0, 0, 1, 0, 0, 32'h0,          1, 32'h8,          1, 32'h0);
    add(0, 0, 1, 0, 0, 32'h0,          1, 32'hC,          1, 32'h0);
    add(0, 0, 1, 0, 0, 32'h0,          0, 32'h10,         1, 32'h0);
    add(0, 1, 1, 1, 0, 32'h0,          0, 32'h10,         1, 32'h0);
    add(0, 1, 1, 1, 0, 32'h0,          1, 32'h10,         1, 32'h4);
    add(0, 0, 1, 1, 0, 32'h0,          1, 32'h14,         1, 32'h8);
    add(0, 0, 1, 1, 0, 32'h0,          0, 32'h18,         1, 32'h8);
    add(0, 0, 1, 1, 1, 32'h103,        0, 32'h18,         1, 32'h8);
    add(0, 1, 1, 0, 0, 32'h0,          1, 32'h100,        0, 32'h0);
    add(0, 1, 1, 0, 0, 32'h0,          1, 32'h104,        0, 32'h0);
    add(0, 1, 1, 0, 0, 32'h0,          1, 32'h108,        0, 32'h0);
    add(0, 1, 1, 0, 0, 32'h0,          1, 32'h10C,        1, 32'h100);
    add(0, 1, 1, 0, 0, 32'h0,          1, 32'h110,        1, 32'h104);
    // Flush coincident with an rvalid and ready=1: no pop, response dropped.
    add(0, 1, 1, 0, 1, 32'h200,        0, 32'h114,        1, 32'h108);
    add(0, 1, 1, 0, 0, 32'h0,          1, 32'h200,        0, 32'h0);
    add(0, 1, 1, 0, 0, 32'h0,          1, 32'h204,        0, 32'h0);
    add(0, 1, 1, 0, 0, 32'h0,          1, 32'h208,        1, 32'h200);
    // Redirect to the top word (low bits ignored): address wraps to 0.
    add(0, 1, 1, 0, 1, 32'hFFFF_FFFE,  0, 32'h20C,        1, 32'h204);
    add(0, 1, 1, 0, 0, 32'h0,          1, 32'hFFFF_FFFC,  0, 32'h0);
    add(0, 1, 1, 0, 0, 32'h0,          1, 32'h0,          0, 32'h0);
    add(0, 1, 1, 0, 0, 32'h0,          1, 32'h4,          1, 32'hFFFF_FFFC);
    add(0, 1, 1, 0, 0, 32'h0,          1, 32'h8,          1, 32'h0);

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec[%0d]", i));

    // Spurious rvalid with nothing outstanding: no push.
    apply(mk(0, 0, 0, 0, 0, 0, 32'h0, 1, 32'hC, 1, 32'h4), "drain");
    apply(mk(0, 0, 0, 0, 0, 1, 32'h0, 1, 32'hC, 1, 32'h4), "spur");
    apply(mk(0, 1, 0, 0, 0, 0, 32'h0, 1, 32'hC, 1, 32'h4), "spur_pop0");
    apply(mk(0, 1, 0, 0, 0, 0, 32'h0, 1, 32'hC, 1, 32'h8), "spur_pop1");
    apply(mk(0, 1, 0, 0, 0, 0, 32'h0, 1, 32'hC, 0, 32'h0), "spur_empty");

    // Async reset in the middle of a burst.
    apply(mk(0, 1, 1, 0, 0, 0, 32'h0, 1, 32'hC,  0, 32'h0), "burst0");
    apply(mk(0, 1, 1, 0, 0, 0, 32'h0, 1, 32'h10, 0, 32'h0), "burst1");
    apply(mk(0, 1, 1, 0, 0, 0, 32'h0, 1, 32'h14, 1, 32'hC), "burst2");
    #2;
    rst = 1'b1;
    exp_q.delete();
    rvalid = 1'b0;
    #1;
    check_outs("async_rst", 1'b0, 32'h0, 1'b0, 32'h0);
    apply(mk(1, 1, 1, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0), "rst_hold");
    apply(mk(0, 1, 1, 0, 0, 0, 32'h0, 1, 32'h0, 0, 32'h0), "rst_rel0");
    apply(mk(0, 1, 1, 0, 0, 0, 32'h0, 1, 32'h4, 0, 32'h0), "rst_rel1");
    apply(mk(0, 1, 1, 0, 0, 0, 32'h0, 1, 32'h8, 1, 32'h0), "rst_rel2");

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/if_prefetch.md
Name: if_prefetch

Overview:
- Instruction fetch front end. Replaces the bare PC-register/ROM pairing ahead of the IF/ID pipeline register.
- Issues sequential word fetches over a request/grant instruction-memory bus and buffers returned instructions with their addresses in a small FIFO.
- Presents them to IF/ID through a valid/ready handshake.
- Supports a flush/redirect from later stages (branch/jump) that discards buffered and in-flight fetches.

Parameters:
- ADDR_WIDTH, 32, instruction address width.
- DATA_WIDTH, 32, instruction width.
- DEPTH, 4, FIFO entries; also the cap on buffered + in-flight fetches (power of 2, >=2).
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- flush_i  input  1  discard all buffered and in-flight fetches; restart at redirect_pc_i.
- redirect_pc_i  input  ADDR_WIDTH  new fetch address; bits [1:0] forced to 0.
- imem_req_o  output  1  fetch request valid.
- imem_addr_o  output  ADDR_WIDTH  fetch address (word aligned).
- imem_gnt_i  input  1  request accepted this cycle when imem_req_o=1.
- imem_rvalid_i  input  1  read data valid; responses return in request order, at least 1 cycle after grant.
- imem_rdata_i  input  DATA_WIDTH  instruction word.
- inst_valid_o  output  1  FIFO head holds a valid instruction.
- inst_ready_i  input  1  IF/ID accepts the head this cycle.
- inst_o  output  DATA_WIDTH  head instruction; 32'h0000_0013 (NOP) when inst_valid_o=0.
- inst_addr_o  output  ADDR_WIDTH  head instruction address; 0 when inst_valid_o=0.

Behaviour:
- Reset (async, any time, including mid-transfer):
  - fetch_pc=RESET_PC, resp_pc=RESET_PC.
  - FIFO count=0, outstanding=0, discard=0.
  - imem_req_o=0, imem_addr_o=RESET_PC, inst_valid_o=0, inst_o=NOP, inst_addr_o=0.
- Issue:
  - imem_req_o = !flush_i && (count + outstanding < DEPTH).
  - imem_addr_o = fetch_pc (registered, always driven).
  - Accept = imem_req_o && imem_gnt_i; on accept, fetch_pc += 4 (wraps modulo 2^ADDR_WIDTH) and outstanding += 1.
  - Request is held with a stable address until granted.
- Response: each imem_rvalid_i with outstanding>0 decrements outstanding.
  - If discard>0: data dropped, discard -= 1.
  - Otherwise: {resp_pc, imem_rdata_i} pushed into the FIFO; resp_pc += 4.
  - rvalid with outstanding==0 is ignored (protocol error; no state change).
- Credit rule (count + outstanding <= DEPTH) guarantees a push never hits a full FIFO. Push and pop in the same cycle are both honoured; count is unchanged.
- Output: first-word fall-through from the FIFO head.
  - inst_valid_o = (count != 0).
  - Pop when inst_valid_o && inst_ready_i.
  - Zero-cycle latency from push to visible at the head on the next cycle: a response at edge N is presented after edge N.
- Flush (flush_i=1 at an edge):
  - FIFO emptied (count=0); any same-cycle pop or push is discarded.
  - fetch_pc = resp_pc = {redirect_pc_i[AW-1:2], 2'b00}.
  - discard = outstanding after this cycle's accept/response accounting: no accept is possible (req forced 0); a response arriving this cycle is dropped.
  - First new request is asserted on the cycle after the flush.
- Back-to-back flushes: each restarts; discard accumulates correctly because outstanding only decrements on rvalid.
- Steady state with gnt=1, rvalid 1 cycle later, ready=1: one instruction per cycle.

Test Plan:
- Reset release, memory grants immediately, rvalid 1 cycle after grant returning addr-as-data, ready=1 -> inst_addr_o 0,4,8,12... on consecutive cycles after a 2-cycle startup; inst_o matches.
- inst_ready_i=0 for 10 cycles -> exactly DEPTH=4 grants issued, then imem_req_o=0. Raise ready -> 0x0,0x4,0x8,0xC delivered in order, then fetch resumes at 0x10.
- Hold imem_gnt_i=0 for 5 cycles -> imem_req_o stays 1 and imem_addr_o stays constant; no fetch_pc advance.
- Two requests in flight (0x10, 0x14) plus FIFO holding 0x8, 0xC; flush_i with redirect 0x103 -> FIFO empty next cycle, both late responses dropped, next delivered inst_addr_o=0x100 then 0x104.
- Flush coincident with an rvalid and with inst_ready_i=1 -> response dropped, no pop, count=0; assert async rst_i mid-burst -> outputs go to reset values immediately, and after release the first fetch is at RESET_PC.
- fetch_pc at 0xFFFF_FFFC -> next request address 0x0000_0000 (wrap); a spurious rvalid with outstanding=0 -> no FIFO push.
